demux_1_2_32bits: RTL and testbench

- 1-to-2 stream demultiplexer; the routing counterpart of the 2:1 32-bit select mux.
- Each incoming 32-bit word is steered, according to Sel, into one of two per-lane FIFOs (lane A when Sel=0, lane B when Sel=1).
- Each lane presents valid/ready outputs, so datapath results can be fanned out to two independently stalling consumers.

---
 rtl/demux_1_2_32bits.sv | 242 ++++++++++++++++++++++++
 tb/tb_demux_1_2_32bits.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_2_32bits.sv
// demux_1_2_32bits: 1-to-2 stream demultiplexer with one FIFO per lane.
// Each accepted word is steered by Sel into lane A (Sel=0) or lane B (Sel=1).
// Each lane drains through its own valid/ready handshake.
//
// Optional build macro DEMUX_1_2_PARITY_EN:
//   - adds the A_Par and B_Par outputs;
//   - stores the even parity (XOR-reduction) of each word next to the word.

// One lane FIFO: DEPTH entries, with a registered occupancy counter.
// The output is the head entry, gated to zero while the lane is empty.
module demux_1_2_lane #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
`ifdef DEMUX_1_2_PARITY_EN
    input  logic             par_i,
    output logic             par_o,
`endif
    input  logic             pop_i,
    output logic [WIDTH-1:0] out_o,
    output logic             valid_o,
    output logic [LVL_W-1:0] level_o,
    output logic             full_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
`ifdef DEMUX_1_2_PARITY_EN
    logic             par_q [DEPTH];
`endif
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] wr_d;
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W-1:0] rd_d;
    logic [LVL_W-1:0] lvl_q;
    logic [LVL_W-1:0] lvl_d;
    logic             push_s;
    logic             pop_s;
    logic             empty_s;

    assign empty_s = (lvl_q == {LVL_W{1'b0}});
    assign full_o  = (lvl_q == LVL_W'(DEPTH));
    assign valid_o = !empty_s;
    assign level_o = lvl_q;

    // Qualify the handshakes.
    // A flush discards both the push and the pop of that cycle.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (flush_i) begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end else begin
            push_s = push_i && !full_o;
            pop_s  = pop_i && !empty_s;
        end
    end

    // Next-state pointers and level.
    // Pointers wrap naturally at PTR_W bits.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        lvl_d = lvl_q;
        if (flush_i) begin
            wr_d  = {PTR_W{1'b0}};
            rd_d  = {PTR_W{1'b0}};
            lvl_d = {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_d = wr_q + PTR_W'(1);
            end else begin
                wr_d = wr_q;
            end
            if (pop_s) begin
                rd_d = rd_q + PTR_W'(1);
            end else begin
                rd_d = rd_q;
            end
            case ({push_s, pop_s})
                2'b10:   lvl_d = lvl_q + LVL_W'(1);
                2'b01:   lvl_d = lvl_q - LVL_W'(1);
                default: lvl_d = lvl_q;
            endcase
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= {PTR_W{1'b0}};
            rd_q  <= {PTR_W{1'b0}};
            lvl_q <= {LVL_W{1'b0}};
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end

    // Entry storage.
    // It is written at the tail on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
`ifdef DEMUX_1_2_PARITY_EN
                par_q[i] <= 1'b0;
`endif
            end
        end else if (push_s) begin
            mem_q[wr_q] <= data_i;
`ifdef DEMUX_1_2_PARITY_EN
            par_q[wr_q] <= par_i;
`endif
        end
    end

    // Present the head entry.
    // It is forced to zero while the lane is empty.
    always_comb begin
        out_o = {WIDTH{1'b0}};
`ifdef DEMUX_1_2_PARITY_EN
        par_o = 1'b0;
`endif
        if (!empty_s) begin
            out_o = mem_q[rd_q];
`ifdef DEMUX_1_2_PARITY_EN
            par_o = par_q[rd_q];
`endif
        end else begin
            out_o = {WIDTH{1'b0}};
`ifdef DEMUX_1_2_PARITY_EN
            par_o = 1'b0;
`endif
        end
    end

endmodule

// Top level: lane steering plus the shared In_Ready.
module demux_1_2_32bits #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Flush,
    input  logic [WIDTH-1:0] In,
    input  logic             Sel,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] A_Out,
    output logic             A_Valid,
    input  logic             A_Ready,
    output logic [LVL_W-1:0] A_Level,
    output logic [WIDTH-1:0] B_Out,
    output logic             B_Valid,
    input  logic             B_Ready,
    output logic [LVL_W-1:0] B_Level
`ifdef DEMUX_1_2_PARITY_EN
    ,
    output logic             A_Par,
    output logic             B_Par
`endif
);

`ifdef DEMUX_1_2_PARITY_EN
    // Even parity of a data word (XOR-reduction).
    function automatic logic even_par(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    logic in_par_s;
    assign in_par_s = even_par(In);
`endif

    logic a_full_s;
    logic b_full_s;
    logic a_push_s;
    logic b_push_s;

    // In_Ready follows only the selected lane's full flag and Flush.
    // A pop in the same cycle does not open a full lane.
    always_comb begin
        In_Ready = 1'b0;
        if (Flush) begin
            In_Ready = 1'b0;
        end else if (Sel) begin
            In_Ready = !b_full_s;
        end else begin
            In_Ready = !a_full_s;
        end
    end

    assign a_push_s = In_Valid && In_Ready && !Sel;
    assign b_push_s = In_Valid && In_Ready && Sel;

    demux_1_2_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_lane_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (Flush),
        .push_i  (a_push_s),
        .data_i  (In),
`ifdef DEMUX_1_2_PARITY_EN
        .par_i   (in_par_s),
        .par_o   (A_Par),
`endif
        .pop_i   (A_Ready),
        .out_o   (A_Out),
        .valid_o (A_Valid),
        .level_o (A_Level),
        .full_o  (a_full_s)
    );

    demux_1_2_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_lane_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (Flush),
        .push_i  (b_push_s),
        .data_i  (In),
`ifdef DEMUX_1_2_PARITY_EN
        .par_i   (in_par_s),
        .par_o   (B_Par),
`endif
        .pop_i   (B_Ready),
        .out_o   (B_Out),
        .valid_o (B_Valid),
        .level_o (B_Level),
        .full_o  (b_full_s)
    );

endmodule

// File: tb/tb_demux_1_2_32bits.sv
// Testbench for demux_1_2_32bits.
// A queue per lane holds the expected words, pushed on modelled accepts and
// popped on modelled pops; each test task compares the DUT against those queues inline.
module tb_demux_1_2_32bits;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int LVL_W = 3;

    logic             clk;
    logic             rst_n;
    logic             Flush;
    logic [WIDTH-1:0] In;
    logic             Sel;
    logic             In_Valid;
    logic             In_Ready;
    logic [WIDTH-1:0] A_Out;
    logic             A_Valid;
    logic             A_Ready;
    logic [LVL_W-1:0] A_Level;
    logic [WIDTH-1:0] B_Out;
    logic             B_Valid;
    logic             B_Ready;
    logic [LVL_W-1:0] B_Level;
`ifdef DEMUX_1_2_PARITY_EN
    logic             A_Par;
    logic             B_Par;
`endif

    int total;
    int bad;

    // Each entry holds {parity, data}.
    logic [WIDTH:0] qa[$];
    logic [WIDTH:0] qb[$];

    demux_1_2_32bits #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Flush    (Flush),
        .In       (In),
        .Sel      (Sel),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .A_Out    (A_Out),
        .A_Valid  (A_Valid),
        .A_Ready  (A_Ready),
        .A_Level  (A_Level),
        .B_Out    (B_Out),
        .B_Valid  (B_Valid),
        .B_Ready  (B_Ready),
        .B_Level  (B_Level)
`ifdef DEMUX_1_2_PARITY_EN
        ,
        .A_Par    (A_Par),
        .B_Par    (B_Par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] head_a();
        logic [WIDTH:0] e;
        if (qa.size() == 0) return '0;
        e = qa[0];
        return e[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] head_b();
        logic [WIDTH:0] e;
        if (qb.size() == 0) return '0;
        e = qb[0];
        return e[WIDTH-1:0];
    endfunction

    // Update the model for the coming edge, then step to 1 ns after that edge.
    task automatic advance();
        logic acc;
        logic pa;
        logic pb;
        logic [WIDTH:0] tmp;
        acc = In_Valid && !Flush && (Sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
        pa  = A_Ready && (qa.size() > 0) && !Flush;
        pb  = B_Ready && (qb.size() > 0) && !Flush;
        if (Flush) begin
            qa.delete();
            qb.delete();
        end else begin
            if (pa) tmp = qa.pop_front();
            if (pb) tmp = qb.pop_front();
            if (acc) begin
                if (Sel) qb.push_back({^In, In});
                else     qa.push_back({^In, In});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        total++; if (A_Valid !== 1'b0 || B_Valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b%b exp=00", A_Valid, B_Valid); end
        total++; if (A_Level !== 3'd0 || B_Level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d/%0d exp=0/0", A_Level, B_Level); end
        total++; if (A_Out !== 32'h0 || B_Out !== 32'h0) begin bad++; $display("FAIL rst_out got=%h/%h exp=0/0", A_Out, B_Out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (In_Ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", In_Ready); end
    endtask

    task automatic test_fifo_order();
        logic [WIDTH-1:0] words [3];
        words[0] = 32'h1111_1111;
        words[1] = 32'h2222_2222;
        words[2] = 32'h3333_3333;
        Sel = 1'b0; A_Ready = 1'b0; In_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            In = words[i];
            advance();
        end
        In_Valid = 1'b0;
        #1;
        total++; if (A_Level !== 3'd3) begin bad++; $display("FAIL order_level got=%0d exp=3", A_Level); end
        total++; if (A_Out !== 32'h1111_1111) begin bad++; $display("FAIL order_head got=%h exp=11111111", A_Out); end
        total++; if (B_Valid !== 1'b0) begin bad++; $display("FAIL order_b_valid got=%b exp=0", B_Valid); end
        advance();
        advance();
        total++; if (A_Out !== 32'h1111_1111) begin bad++; $display("FAIL order_hold got=%h exp=11111111", A_Out); end
        A_Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (A_Valid !== 1'b1 || A_Out !== head_a()) begin bad++; $display("FAIL order_pop%0d got=%b/%h exp=1/%h", i, A_Valid, A_Out, head_a()); end
            advance();
        end
        total++; if (A_Level !== 3'd0 || A_Valid !== 1'b0) begin bad++; $display("FAIL order_empty got=%0d/%b exp=0/0", A_Level, A_Valid); end
        A_Ready = 1'b0;
    endtask

    task automatic test_full();
        B_Ready = 1'b0; A_Ready = 1'b0; Sel = 1'b1; In_Valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            In = 32'hB000_0000 + i;
            advance();
        end
        #1;
        total++; if (In_Ready !== 1'b0) begin bad++; $display("FAIL full_b_ready got=%b exp=0", In_Ready); end
        Sel = 1'b0; In = 32'hA5A5_A5A5;
        #1;
        total++; if (In_Ready !== 1'b1) begin bad++; $display("FAIL full_a_ready got=%b exp=1", In_Ready); end
        advance();
        total++; if (A_Level !== 3'd1 || B_Level !== 3'd4) begin bad++; $display("FAIL full_levels got=%0d/%0d exp=1/4", A_Level, B_Level); end
        total++; if (A_Out !== 32'hA5A5_A5A5) begin bad++; $display("FAIL full_a_out got=%h exp=a5a5a5a5", A_Out); end
        Sel = 1'b1; B_Ready = 1'b1; In = 32'hBAD0_BAD0;
        #1;
        total++; if (In_Ready !== 1'b0) begin bad++; $display("FAIL full_no_pass got=%b exp=0", In_Ready); end
        advance();
        In_Valid = 1'b0; A_Ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (B_Out !== head_b() || A_Out !== head_a()) begin bad++; $display("FAIL full_drain%0d got=%h/%h exp=%h/%h", i, A_Out, B_Out, head_a(), head_b()); end
            advance();
        end
        total++; if (A_Level !== 3'd0 || B_Level !== 3'd0) begin bad++; $display("FAIL full_drained got=%0d/%0d exp=0/0", A_Level, B_Level); end
        A_Ready = 1'b0; B_Ready = 1'b0;
    endtask

    task automatic test_push_pop_same();
        Sel = 1'b0; A_Ready = 1'b0; In_Valid = 1'b1;
        In = 32'hC000_0000; advance();
        In = 32'hC000_0001; advance();
        In = 32'hDEAD_BEEF; A_Ready = 1'b1;
        #1;
        total++; if (A_Out !== head_a()) begin bad++; $display("FAIL pp_head got=%h exp=%h", A_Out, head_a()); end
        advance();
        total++; if (A_Level !== 3'd2) begin bad++; $display("FAIL pp_level got=%0d exp=2", A_Level); end
        for (int i = 0; i < 10; i++) begin
            In = $urandom;
            #1;
            total++; if (A_Out !== head_a() || A_Level !== 3'd2) begin bad++; $display("FAIL pp_wrap%0d got=%h/%0d exp=%h/2", i, A_Out, A_Level, head_a()); end
            advance();
        end
        In_Valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++; if (A_Out !== head_a()) begin bad++; $display("FAIL pp_drain%0d got=%h exp=%h", i, A_Out, head_a()); end
            advance();
        end
        total++; if (A_Valid !== 1'b0) begin bad++; $display("FAIL pp_empty got=%b exp=0", A_Valid); end
        A_Ready = 1'b0;
    endtask

    task automatic test_flush();
        A_Ready = 1'b0; B_Ready = 1'b0; In_Valid = 1'b1;
        Sel = 1'b0;
        for (int i = 0; i < 2; i++) begin In = 32'hF0A0_0000 + i; advance(); end
        Sel = 1'b1;
        for (int i = 0; i < 3; i++) begin In = 32'hF0B0_0000 + i; advance(); end
        Sel = 1'b0; In = 32'hFFFF_0000; Flush = 1'b1; A_Ready = 1'b1;
        #1;
        total++; if (In_Ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", In_Ready); end
        total++; if (A_Level !== 3'd2 || B_Level !== 3'd3) begin bad++; $display("FAIL flush_pre got=%0d/%0d exp=2/3", A_Level, B_Level); end
        advance();
        Flush = 1'b0; In_Valid = 1'b0; A_Ready = 1'b0;
        #1;
        total++; if (A_Level !== 3'd0 || B_Level !== 3'd0) begin bad++; $display("FAIL flush_levels got=%0d/%0d exp=0/0", A_Level, B_Level); end
        total++; if (A_Valid !== 1'b0 || B_Valid !== 1'b0 || A_Out !== 32'h0) begin bad++; $display("FAIL flush_valid got=%b%b/%h exp=00/0", A_Valid, B_Valid, A_Out); end
        In_Valid = 1'b1; In = 32'h5A5A_0001;
        advance();
        In_Valid = 1'b0;
        total++; if (A_Out !== head_a() || A_Level !== 3'd1) begin bad++; $display("FAIL flush_after got=%h/%0d exp=%h/1", A_Out, A_Level, head_a()); end
        A_Ready = 1'b1; advance(); A_Ready = 1'b0;
    endtask

    task automatic test_async_reset();
        In_Valid = 1'b1;
        Sel = 1'b0; In = 32'h0123_4567; advance();
        Sel = 1'b1; In = 32'h89AB_CDEF; advance();
        In_Valid = 1'b0;
        total++; if (A_Valid !== 1'b1 || B_Valid !== 1'b1) begin bad++; $display("FAIL ares_pre got=%b%b exp=11", A_Valid, B_Valid); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (A_Valid !== 1'b0 || B_Valid !== 1'b0) begin bad++; $display("FAIL ares_valid got=%b%b exp=00", A_Valid, B_Valid); end
        total++; if (A_Level !== 3'd0 || B_Level !== 3'd0 || A_Out !== 32'h0 || B_Out !== 32'h0) begin bad++; $display("FAIL ares_state got=%0d/%0d/%h/%h exp=0/0/0/0", A_Level, B_Level, A_Out, B_Out); end
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (A_Valid !== 1'b0 || B_Level !== 3'd0) begin bad++; $display("FAIL ares_release got=%b/%0d exp=0/0", A_Valid, B_Level); end
    endtask

`ifdef DEMUX_1_2_PARITY_EN
    task automatic test_parity();
        In_Valid = 1'b1;
        Sel = 1'b0; In = 32'h0000_0001; advance();
        Sel = 1'b1; In = 32'h0000_0003; advance();
        In_Valid = 1'b0;
        total++; if (A_Par !== 1'b1 || B_Par !== 1'b0) begin bad++; $display("FAIL parity got=%b/%b exp=1/0", A_Par, B_Par); end
        A_Ready = 1'b1; B_Ready = 1'b1;
        advance();
        A_Ready = 1'b0; B_Ready = 1'b0;
        total++; if (A_Par !== 1'b0 || B_Par !== 1'b0) begin bad++; $display("FAIL parity_empty got=%b/%b exp=0/0", A_Par, B_Par); end
    endtask
`endif

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; Flush = 1'b0; In = '0; Sel = 1'b0;
        In_Valid = 1'b0; A_Ready = 1'b0; B_Ready = 1'b0;
        test_reset();
        test_fifo_order();
        test_full();
        test_push_pop_same();
        test_flush();
        test_async_reset();
`ifdef DEMUX_1_2_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
